// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//   800x600 @72 Hz raster timing generator for the snake game, running on the
//   100 MHz board clock with a 50 MHz pixel-rate clock enable. It also
//   produces update_clock, a one-cycle game-step strobe issued once every
//   FRAMES_PER_UPDATE whole frames.
//
// Ports
//   CLK_100MHz   in   1  system clock (100 MHz)
//   reset        in   1  asynchronous active-low reset (0 = in reset)
//   CurrentX     out 10  horizontal pixel counter, 0..H_TOT-1
//   CurrentY     out 10  vertical line counter, 0..V_TOT-1
//   HS           out  1  horizontal sync, active level SYNC_POL
//   VS           out  1  vertical sync, active level SYNC_POL (whole lines)
//   displayArea  out  1  high while (CurrentX,CurrentY) is in the visible area
//   update_clock out  1  one-CLK pulse every FRAMES_PER_UPDATE frames
//   pix_en       out  1  pixel-rate enable, high every second CLK cycle
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int unsigned H_VIS             = 800,
    parameter int unsigned H_FP              = 56,
    parameter int unsigned H_SYNC            = 120,
    parameter int unsigned H_BP              = 64,
    parameter int unsigned V_VIS             = 600,
    parameter int unsigned V_FP              = 37,
    parameter int unsigned V_SYNC            = 6,
    parameter int unsigned V_BP              = 23,
    parameter bit          SYNC_POL          = 1'b1,
    parameter int unsigned FRAMES_PER_UPDATE = 6
) (
    input  logic       CLK_100MHz,
    input  logic       reset,
    output logic [9:0] CurrentX,
    output logic [9:0] CurrentY,
    output logic       HS,
    output logic       VS,
    output logic       displayArea,
    output logic       update_clock,
    output logic       pix_en
);

    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_END  = 10'(V_VIS);
    localparam logic [9:0] HS_FIRST   = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_VIS + V_FP + V_SYNC - 1);
    localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_UPDATE - 1);
    localparam logic       SYNC_ON    = SYNC_POL;
    localparam logic       SYNC_OFF   = ~SYNC_POL;

    // Inclusive range test used for the sync window decodes.
    function automatic logic in_window(input logic [9:0] v,
                                       input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    logic       pix_en_r;
    logic [9:0] x_r;
    logic [9:0] y_r;
    logic       hs_r;
    logic       vs_r;
    logic       da_r;
    logic       upd_r;
    logic [7:0] frame_cnt_r;

    logic [9:0] x_next_s;
    logic [9:0] y_next_s;
    logic       eof_s;
    logic       hs_next_s;
    logic       vs_next_s;
    logic       da_next_s;
    logic [7:0] frame_next_s;
    logic       upd_next_s;

    // Next raster position: advance one pixel on pixel-enable cycles, wrapping
    // line and frame at their last positions.
    always_comb begin
        x_next_s = x_r;
        y_next_s = y_r;
        eof_s    = 1'b0;
        if (pix_en_r) begin
            if (x_r == H_LAST) begin
                x_next_s = 10'd0;
                if (y_r == V_LAST) begin
                    y_next_s = 10'd0;
                    eof_s    = 1'b1;
                end else begin
                    y_next_s = y_r + 10'd1;
                end
            end else begin
                x_next_s = x_r + 10'd1;
            end
        end else begin
            x_next_s = x_r;
            y_next_s = y_r;
        end
    end

    // Decodes are taken from the next position so the registered syncs and
    // visible flag change on the same edge as the coordinates. VS follows
    // y_next only, so it can only change when the line wraps.
    always_comb begin
        hs_next_s = in_window(x_next_s, HS_FIRST, HS_LAST) ? SYNC_ON : SYNC_OFF;
        vs_next_s = in_window(y_next_s, VS_FIRST, VS_LAST) ? SYNC_ON : SYNC_OFF;
        da_next_s = (x_next_s < H_VIS_END) && (y_next_s < V_VIS_END);
    end

    // Frame divider for the game-step strobe; the pulse lands on the edge
    // where the raster returns to (0,0).
    always_comb begin
        frame_next_s = frame_cnt_r;
        upd_next_s   = 1'b0;
        if (eof_s) begin
            if (frame_cnt_r == FRAME_LAST) begin
                frame_next_s = 8'd0;
                upd_next_s   = 1'b1;
            end else begin
                frame_next_s = frame_cnt_r + 8'd1;
            end
        end else begin
            frame_next_s = frame_cnt_r;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK_100MHz or negedge reset) begin
        if (!reset) begin
            pix_en_r    <= 1'b0;
            x_r         <= 10'd0;
            y_r         <= 10'd0;
            hs_r        <= SYNC_OFF;
            vs_r        <= SYNC_OFF;
            da_r        <= 1'b1;
            upd_r       <= 1'b0;
            frame_cnt_r <= 8'd0;
        end else begin
            pix_en_r    <= ~pix_en_r;
            x_r         <= x_next_s;
            y_r         <= y_next_s;
            hs_r        <= hs_next_s;
            vs_r        <= vs_next_s;
            da_r        <= da_next_s;
            upd_r       <= upd_next_s;
            frame_cnt_r <= frame_next_s;
        end
    end

    assign pix_en       = pix_en_r;
    assign CurrentX     = x_r;
    assign CurrentY     = y_r;
    assign HS           = hs_r;
    assign VS           = vs_r;
    assign displayArea  = da_r;
    assign update_clock = upd_r;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the 800x600 @72 Hz raster timing for the snake game from the 100 MHz board clock.
- Drives the pixel coordinates (CurrentX/CurrentY), the syncs (HS/VS) and the visible-area flag consumed by the snake/apple/border renderer directly downstream.
- Also produces update_clock, the slow game-step strobe that advances the snake body, derived by counting whole frames.
- Pixel rate is 50 MHz, realised as a clock enable (pix_en) on CLK_100MHz; there is no second clock domain.

Parameters:
H_VIS, 800, visible pixels per line
H_FP, 56, horizontal front porch (pixels)
H_SYNC, 120, horizontal sync width (pixels)
H_BP, 64, horizontal back porch (pixels)
V_VIS, 600, visible lines per frame
V_FP, 37, vertical front porch (lines)
V_SYNC, 6, vertical sync width (lines)
V_BP, 23, vertical back porch (lines)
SYNC_POL, 1, sync active level (1 = active-high)
FRAMES_PER_UPDATE, 6, frames per update_clock pulse (legal range 1..255)

Ports:
CLK_100MHz  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-low reset (0 = in reset)
CurrentX  out  10  horizontal pixel counter, 0..H_TOT-1
CurrentY  out  10  vertical line counter, 0..V_TOT-1
HS  out  1  horizontal sync
VS  out  1  vertical sync
displayArea  out  1  1 when CurrentX<H_VIS and CurrentY<V_VIS
update_clock  out  1  one-CLK-cycle high pulse every FRAMES_PER_UPDATE frames
pix_en  out  1  pixel-rate enable, high every 2nd CLK cycle

Behaviour:
- Totals: H_TOT = H_VIS+H_FP+H_SYNC+H_BP = 1040; V_TOT = V_VIS+V_FP+V_SYNC+V_BP = 666.
- All state is flopped on posedge CLK_100MHz, with asynchronous clear on negedge reset.
- Reset values:
  - pix_en=0, CurrentX=0, CurrentY=0, frame counter=0, update_clock=0.
  - displayArea=1, because (0,0) is visible.
  - HS=VS=~SYNC_POL (inactive).
- pix_en toggles every CLK cycle out of reset. The first cycle after reset release drives pix_en=1. Counters advance only on a CLK edge where pix_en==1, so CurrentX first becomes 1 at the 2nd rising edge after reset release.
- Horizontal counter:
  - On an advancing edge, CurrentX increments.
  - At CurrentX==H_TOT-1 it wraps to 0 and CurrentY increments.
  - At CurrentY==V_TOT-1 with that same wrap, CurrentY wraps to 0 (end of frame).
- HS/VS/displayArea are registered decodes of the next counter values, so they change on the same CLK edge as CurrentX/CurrentY (zero skew, no extra latency).
  - HS = SYNC_POL when CurrentX in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] = [856,975], else ~SYNC_POL.
  - VS = SYNC_POL when CurrentY in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1] = [637,642], else ~SYNC_POL.
  - VS is a whole-line signal: it changes only on the edge where CurrentX wraps to 0.
- Frame counter (8 bit):
  - On each end-of-frame edge it increments.
  - If it equals FRAMES_PER_UPDATE-1 instead, it wraps to 0 and update_clock is driven 1 for exactly that one CLK cycle, coincident with (CurrentX,CurrentY) becoming (0,0).
  - update_clock is 0 at all other times.
  - With FRAMES_PER_UPDATE=1 the pulse occurs every frame.
- Counters never exceed H_TOT-1 / V_TOT-1. There is no illegal state reachable from reset.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronously). After release, timing restarts from (0,0), and the frame counter restarts at 0, so the first update_clock follows FRAMES_PER_UPDATE full frames.
- Downstream stages sample CurrentX/CurrentY with registered logic. This block guarantees the coordinates are stable for 2 CLK cycles per pixel.

Test Plan:
- Reset/startup: hold reset=0 for 5 cycles, then release → during reset CurrentX=CurrentY=0, HS=VS=0, displayArea=1, update_clock=0; pix_en=1 on the 1st cycle after release; CurrentX=1 after the 2nd edge.
- Line timing: run 1 line → CurrentX goes 0..1039 then back to 0 with CurrentY=1; one line = 2080 CLK; HS high for exactly 240 CLK starting when CurrentX=856; displayArea falls when CurrentX=800.
- Frame timing: run 2 frames → 1,385,280 CLK per frame; VS high for 6 lines (12,480 CLK) with CurrentY 637..642; displayArea=0 for all CurrentY>=600; CurrentY wraps 665→0.
- Update strobe: default parameters, run 13 frames → update_clock pulses exactly twice, each 1 CLK wide, at the starts of frames 6 and 12 (counting the first frame as 0), spaced 8,311,680 CLK apart, each coincident with CurrentX=CurrentY=0.
- Reset mid-operation: assert reset at CurrentX=500, CurrentY=300 for 3 cycles → outputs go to reset values asynchronously; after release the next update_clock arrives 6 full frames later.
- FRAMES_PER_UPDATE=1 with SYNC_POL=0 → update_clock pulses every frame (every 1,385,280 CLK); HS/VS idle high and pulse low over the same windows as the default test.
